// File: rtl/cmos_capture_multi_fmt.sv
// cmos_capture_multi_fmt: DVP byte-to-pixel packer (RAW8/RGB565/RGB888) with settle skip, geometry, error and fps stats
module cmos_capture_multi_fmt #(
  parameter int   FRAME_WAITCNT = 10,
  parameter logic VS_ACTIVE     = 1'b1,
  parameter int   CNT_W         = 12,
  parameter int   PCLK_FREQ_HZ  = 24_000_000
) (
  input  logic             cmos_pclk,
  input  logic             rst,
  input  logic             cmos_vsync,
  input  logic             cmos_href,
  input  logic [7:0]       cmos_din,
  input  logic             capture_en,
  input  logic [1:0]       fmt_mode,
  output logic             frame_vsync,
  output logic             frame_href,
  output logic [23:0]      frame_data,
  output logic             frame_clken,
  output logic             frame_start,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_width,
  output logic [CNT_W-1:0] frame_height,
  output logic [7:0]       partial_err_cnt,
  output logic [7:0]       fps_rate
);
  localparam int WIN_W = PCLK_FREQ_HZ > 1 ? $clog2(PCLK_FREQ_HZ) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [15:0] SETTLE_N = 16'(FRAME_WAITCNT);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(PCLK_FREQ_HZ - 1);
  typedef enum logic [1:0] {S_SETTLE, S_IDLE, S_CAPTURE} state_t;
  state_t state, state_nx;
  logic vs1, vs2, hr1, hr2;
  logic [7:0] din1, b0, b1, fps_cnt;
  logic [15:0] settle_cnt;
  logic [1:0] fmt, idx;
  logic [23:0] pix_data, pixel;
  logic [CNT_W-1:0] pix_cnt, line_cnt, width_cand;
  logic [WIN_W-1:0] win_cnt;
  logic vs_end, vs_start, cap, go, stop, win_end;
  assign vs_end = (vs2 == VS_ACTIVE) && (vs1 != VS_ACTIVE);
  assign vs_start = (vs2 != VS_ACTIVE) && (vs1 == VS_ACTIVE);
  assign cap = state == S_CAPTURE;
  assign win_end = win_cnt == WIN_LAST;
  // fmt is stored normalised to 0/1/2, which is also the index of the last byte of a pixel
  assign pixel = fmt == 2'd0 ? {16'h0, din1} : fmt == 2'd1 ? {8'h0, b0, din1} : {b0, b1, din1};
  assign frame_vsync = cap & vs2;
  assign frame_href = cap & hr2;
  assign frame_data = frame_href ? pix_data : 24'h0;
  always_comb begin
    state_nx = state;
    go = 1'b0;
    stop = 1'b0;
    case (state)
      S_SETTLE: if (vs_end && settle_cnt == SETTLE_N) state_nx = S_IDLE;
      S_IDLE: if (vs_end && capture_en) begin
        state_nx = S_CAPTURE;
        go = 1'b1;
      end
      S_CAPTURE: if (vs_start) begin
        state_nx = S_IDLE;
        stop = 1'b1;
      end
      default: state_nx = S_SETTLE;
    endcase
  end
  always_ff @(posedge cmos_pclk or posedge rst) begin
    if (rst) begin
      {vs1, vs2, hr1, hr2} <= '0;
      din1 <= '0;
      state <= S_SETTLE;
      settle_cnt <= '0;
      frame_start <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      vs1 <= cmos_vsync;
      vs2 <= vs1;
      hr1 <= cmos_href;
      hr2 <= hr1;
      din1 <= cmos_din;
      state <= state_nx;
      frame_start <= go;
      frame_done <= stop;
      if (state == S_SETTLE && vs_end && settle_cnt != SETTLE_N) settle_cnt <= settle_cnt + 1'b1;
    end
  end
  always_ff @(posedge cmos_pclk or posedge rst) begin
    if (rst) begin
      fmt <= '0;
      idx <= '0;
      b0 <= '0;
      b1 <= '0;
      pix_data <= '0;
      frame_clken <= 1'b0;
      pix_cnt <= '0;
      line_cnt <= '0;
      width_cand <= '0;
      frame_width <= '0;
      frame_height <= '0;
      partial_err_cnt <= '0;
    end else begin
      frame_clken <= 1'b0;
      if (go) begin
        fmt <= fmt_mode == 2'd2 ? 2'd2 : fmt_mode == 2'd0 ? 2'd0 : 2'd1;
        idx <= '0;
        pix_cnt <= '0;
        line_cnt <= '0;
        width_cand <= '0;
      end else if (cap && hr1) begin
        if (idx == fmt) begin
          pix_data <= pixel;
          frame_clken <= 1'b1;
          idx <= '0;
          if (pix_cnt != CNT_MAX) pix_cnt <= pix_cnt + 1'b1;
        end else begin
          idx <= idx + 1'b1;
          if (idx == 2'd0) b0 <= din1;
          else b1 <= din1;
        end
      end else if (cap && hr2) begin
        // line end: a byte index left mid-pixel means the sensor cut a pixel short
        if (idx != 2'd0 && partial_err_cnt != 8'hFF) partial_err_cnt <= partial_err_cnt + 1'b1;
        idx <= '0;
        if (line_cnt != CNT_MAX) line_cnt <= line_cnt + 1'b1;
        width_cand <= pix_cnt;
        pix_cnt <= '0;
      end
      if (stop) begin
        frame_width <= width_cand;
        frame_height <= line_cnt;
      end
    end
  end
  always_ff @(posedge cmos_pclk or posedge rst) begin
    if (rst) begin
      win_cnt <= '0;
      fps_cnt <= '0;
      fps_rate <= '0;
    end else begin
      win_cnt <= win_end ? '0 : win_cnt + 1'b1;
      if (win_end) begin
        fps_rate <= fps_cnt;
        fps_cnt <= {7'h0, frame_done};
      end else if (frame_done && fps_cnt != 8'hFF) fps_cnt <= fps_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_cmos_capture_multi_fmt.sv
// tb_cmos_capture_multi_fmt: directed bench for the DVP capture front-end
module tb_cmos_capture_multi_fmt;
  logic clk = 1'b0, rst = 1'b1, vsync = 1'b1, href = 1'b0, en = 1'b1;
  logic [7:0] din = '0;
  logic [1:0] fmt = 2'd1;
  logic f_vs, f_hr, f_clken, f_start, f_done;
  logic [23:0] f_data, last_data;
  logic [11:0] f_width, f_height;
  logic [7:0] perr, fps;
  int checks = 0, errors = 0;
  int n_clken = 0, n_start = 0, n_done = 0, cyc = 0;

  cmos_capture_multi_fmt #(.FRAME_WAITCNT(2), .VS_ACTIVE(1'b1), .CNT_W(12), .PCLK_FREQ_HZ(1000)) dut (
    .cmos_pclk(clk), .rst(rst), .cmos_vsync(vsync), .cmos_href(href), .cmos_din(din),
    .capture_en(en), .fmt_mode(fmt), .frame_vsync(f_vs), .frame_href(f_hr), .frame_data(f_data),
    .frame_clken(f_clken), .frame_start(f_start), .frame_done(f_done), .frame_width(f_width),
    .frame_height(f_height), .partial_err_cnt(perr), .fps_rate(fps));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (f_clken) begin
      n_clken++;
      last_data = f_data;
    end
    if (f_start) n_start++;
    if (f_done) n_done++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_line(input int n, input logic [7:0] start, input logic [7:0] step);
    logic [7:0] v;
    v = start;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      href = 1'b1;
      din = v;
      v = v + step;
    end
    @(negedge clk);
    href = 1'b0;
    din = '0;
    tick(3);
  endtask

  task automatic frame_open();
    @(negedge clk);
    vsync = 1'b0;
    tick(3);
  endtask

  task automatic frame_close();
    @(negedge clk);
    vsync = 1'b1;
    tick(4);
  endtask

  task automatic test_reset();
    tick(3);
    if ({f_vs, f_hr, f_data, f_clken, f_start, f_done, f_width, f_height, perr, fps} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got data=%h w=%0d h=%0d", f_data, f_width, f_height);
    end
    checks++;
    @(negedge clk);
    rst = 1'b0;
    tick(3);
  endtask

  task automatic test_settle();
    int c0, s0, d0;
    c0 = n_clken; s0 = n_start; d0 = n_done;
    fmt = 2'd1;
    en = 1'b1;
    for (int f = 0; f < 3; f++) begin
      frame_open();
      for (int l = 0; l < 4; l++) send_line(8, 8'(l * 16), 8'h01);
      frame_close();
    end
    if (n_clken - c0 !== 0) begin errors++; $display("FAIL settle_skip clken got %0d want 0", n_clken - c0); end
    checks++;
    if (n_start - s0 !== 0) begin errors++; $display("FAIL settle_skip start got %0d want 0", n_start - s0); end
    checks++;
    frame_open();
    for (int l = 0; l < 4; l++) send_line(8, 8'(l * 16), 8'h01);
    frame_close();
    if (n_clken - c0 !== 16) begin errors++; $display("FAIL settle_f4 clken got %0d want 16", n_clken - c0); end
    checks++;
    if (n_start - s0 !== 1) begin errors++; $display("FAIL settle_f4 start got %0d want 1", n_start - s0); end
    checks++;
    if (n_done - d0 !== 1) begin errors++; $display("FAIL settle_f4 done got %0d want 1", n_done - d0); end
    checks++;
    if (f_width !== 12'd4) begin errors++; $display("FAIL settle_width got %0d want 4", f_width); end
    checks++;
    if (f_height !== 12'd4) begin errors++; $display("FAIL settle_height got %0d want 4", f_height); end
    checks++;
    if (last_data !== 24'h003637) begin errors++; $display("FAIL settle_pix565 got %h want 003637", last_data); end
    checks++;
  endtask

  task automatic test_rgb888();
    fmt = 2'd2;
    frame_open();
    @(negedge clk); href = 1'b1; din = 8'h11;
    @(negedge clk); din = 8'h22;
    @(negedge clk); din = 8'h33;
    @(negedge clk); href = 1'b0; din = '0;
    if (f_clken !== 1'b0) begin errors++; $display("FAIL rgb888_early clken got %b want 0", f_clken); end
    checks++;
    @(negedge clk);
    if (f_clken !== 1'b1) begin errors++; $display("FAIL rgb888_strobe clken got %b want 1", f_clken); end
    checks++;
    if (f_data !== 24'h112233) begin errors++; $display("FAIL rgb888_data got %h want 112233", f_data); end
    checks++;
    @(negedge clk);
    if (f_clken !== 1'b0) begin errors++; $display("FAIL rgb888_pulse clken got %b want 0", f_clken); end
    checks++;
    if (f_data !== 24'h0) begin errors++; $display("FAIL rgb888_gate data got %h want 000000", f_data); end
    checks++;
    tick(3);
    frame_close();
    if (f_width !== 12'd1 || f_height !== 12'd1) begin
      errors++; $display("FAIL rgb888_geom got %0dx%0d want 1x1", f_width, f_height);
    end
    checks++;
  endtask

  task automatic test_raw8();
    int c0;
    c0 = n_clken;
    fmt = 2'd0;
    frame_open();
    send_line(1, 8'hA5, 8'h00);
    if (last_data !== 24'h0000A5) begin errors++; $display("FAIL raw8_data got %h want 0000a5", last_data); end
    checks++;
    frame_close();
    if (n_clken - c0 !== 1) begin errors++; $display("FAIL raw8_clken got %0d want 1", n_clken - c0); end
    checks++;
  endtask

  task automatic test_partial();
    int c0;
    c0 = n_clken;
    fmt = 2'd1;
    frame_open();
    send_line(7, 8'h40, 8'h01);
    frame_close();
    if (n_clken - c0 !== 3) begin errors++; $display("FAIL partial_clken got %0d want 3", n_clken - c0); end
    checks++;
    if (perr !== 8'd1) begin errors++; $display("FAIL partial_err got %0d want 1", perr); end
    checks++;
    if (f_width !== 12'd3) begin errors++; $display("FAIL partial_width got %0d want 3", f_width); end
    checks++;
    if (f_height !== 12'd1) begin errors++; $display("FAIL partial_height got %0d want 1", f_height); end
    checks++;
    if (last_data !== 24'h004445) begin errors++; $display("FAIL partial_data got %h want 004445", last_data); end
    checks++;
  endtask

  task automatic test_mid_switch();
    int c0, s0, d0;
    c0 = n_clken; s0 = n_start; d0 = n_done;
    fmt = 2'd1;
    en = 1'b1;
    frame_open();
    send_line(4, 8'h50, 8'h01);
    fmt = 2'd0;
    en = 1'b0;
    send_line(4, 8'h60, 8'h01);
    frame_close();
    if (n_clken - c0 !== 4) begin errors++; $display("FAIL switch_clken got %0d want 4", n_clken - c0); end
    checks++;
    if (last_data !== 24'h006263) begin errors++; $display("FAIL switch_data got %h want 006263", last_data); end
    checks++;
    if (n_done - d0 !== 1) begin errors++; $display("FAIL switch_done got %0d want 1", n_done - d0); end
    checks++;
    if (f_width !== 12'd2 || f_height !== 12'd2) begin
      errors++; $display("FAIL switch_geom got %0dx%0d want 2x2", f_width, f_height);
    end
    checks++;
    c0 = n_clken; d0 = n_done;
    frame_open();
    send_line(4, 8'h70, 8'h01);
    frame_close();
    if (n_start - s0 !== 1) begin errors++; $display("FAIL disabled_start got %0d want 1", n_start - s0); end
    checks++;
    if (n_clken - c0 !== 0 || n_done - d0 !== 0) begin
      errors++; $display("FAIL disabled_frame clken=%0d done=%0d want 0 0", n_clken - c0, n_done - d0);
    end
    checks++;
  endtask

  task automatic test_fps();
    int d0, t0;
    en = 1'b1;
    fmt = 2'd0;
    @(negedge clk);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    t0 = cyc;
    d0 = n_done;
    for (int f = 0; f < 8; f++) begin
      frame_open();
      send_line(2, 8'h80, 8'h01);
      frame_close();
    end
    if (n_done - d0 !== 5) begin errors++; $display("FAIL fps_done got %0d want 5", n_done - d0); end
    checks++;
    while (cyc < t0 + 990) @(negedge clk);
    if (fps !== 8'd0) begin errors++; $display("FAIL fps_before got %0d want 0", fps); end
    checks++;
    while (cyc < t0 + 1010) @(negedge clk);
    if (fps !== 8'd5) begin errors++; $display("FAIL fps_rate got %0d want 5", fps); end
    checks++;
  endtask

  task automatic test_reset_mid();
    int c0, d0;
    en = 1'b1;
    fmt = 2'd1;
    frame_open();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      href = 1'b1;
      din = 8'(i);
    end
    if (f_hr !== 1'b1) begin errors++; $display("FAIL midreset_pre href got %b want 1", f_hr); end
    checks++;
    d0 = n_done;
    rst = 1'b1;
    #1;
    if ({f_vs, f_hr, f_data, f_clken, f_start, f_done, f_width, f_height, perr, fps} !== '0) begin
      errors++; $display("FAIL midreset_outputs got data=%h w=%0d perr=%0d fps=%0d", f_data, f_width, perr, fps);
    end
    checks++;
    tick(2);
    rst = 1'b0;
    c0 = n_clken;
    tick(2);
    href = 1'b0;
    tick(2);
    vsync = 1'b1;
    tick(6);
    if (n_done - d0 !== 0 || n_clken - c0 !== 0) begin
      errors++; $display("FAIL midreset_after done=%0d clken=%0d want 0 0", n_done - d0, n_clken - c0);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_settle();
    test_rgb888();
    test_raw8();
    test_partial();
    test_mid_switch();
    test_fps();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
